// File: rtl/core_phase_sequencer_pkg.sv
// Shared definitions for the core phase sequencer: state encoding and
// default parameter values used by the top and the wait timer.
package core_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEMACC = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 256;
  localparam int unsigned TMO_W_DEF       = 9;
  localparam int unsigned CNT_W_DEF       = 32;

endpackage

// File: rtl/core_wait_timer.sv
// Wait-cycle counter for one outstanding memory handshake. Counts cycles
// while i_en is high, clears on i_clr, and flags the cycle on which the
// last permitted wait cycle is still waiting. TIMEOUT_CYC = 0 disables expiry.
module core_wait_timer
  import core_phase_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TMO_W       = TMO_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam bit               TMO_ON = (TIMEOUT_CYC != 0);
  localparam logic [TMO_W-1:0] LAST   = TMO_ON ? TMO_W'(TIMEOUT_CYC - 1) : '0;

  logic [TMO_W-1:0] r_count;

  // Wait-cycle counter: cleared between handshakes, counts while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  assign o_expire = TMO_ON && i_en && (r_count == LAST);

endmodule

// File: rtl/core_phase_sequencer.sv
// Phase controller for the multi-cycle RV core: sequences
// FETCH/DECODE/EXECUTE/MEMACC/WRITEBACK with req/ack memory handshakes,
// a shared handshake timeout, halt at instruction boundaries and a
// retired-instruction counter.
// Build option: define CORE_PHASE_SKIP_MEM_EN to let non-memory ops go
// straight from EXECUTE to WRITEBACK (4-cycle ops); undefined keeps the
// fixed 5-phase timing of the legacy core.
module core_phase_sequencer
  import core_phase_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TMO_W       = TMO_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             mem_op_de,
  input  logic             halt_req,
  output logic             halted,
  output logic             bus_err,
  output logic             phase_fetch,
  output logic             phase_decode,
  output logic             phase_execute,
  output logic             phase_memoryaccess,
  output logic             phase_writeback,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             stall_execute,
  output logic             stall_memoryaccess,
  output logic             stall_writeback,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_next;
  logic             w_wait_en;
  logic             w_expire;
  logic [CNT_W-1:0] r_instret;

  // Only one handshake is ever outstanding, so FETCH and MEMACC share one timer;
  // any cycle that is not a waiting cycle ends (or is outside) a handshake.
  assign w_wait_en = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);

  core_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (~w_wait_en),
    .i_en     (w_wait_en),
    .o_expire (w_expire)
  );

  // State register; async reset drops every request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_next;
  end

  // Next-state and one-hot phase/request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    w_next             = r_state;
    phase_fetch        = 1'b0;
    phase_decode       = 1'b0;
    phase_execute      = 1'b0;
    phase_memoryaccess = 1'b0;
    phase_writeback    = 1'b0;
    imem_req           = 1'b0;
    dmem_req           = 1'b0;
    halted             = 1'b0;
    bus_err            = 1'b0;
    case (r_state)
      ST_BOOT: w_next = ST_FETCH;
      ST_FETCH: begin
        phase_fetch = 1'b1;
        imem_req    = 1'b1;
        if (imem_ack)      w_next = ST_DECODE;
        else if (w_expire) w_next = ST_ERR;
      end
      ST_DECODE: begin
        phase_decode = 1'b1;
        w_next       = ST_EXEC;
      end
      ST_EXEC: begin
        phase_execute = 1'b1;
`ifdef CORE_PHASE_SKIP_MEM_EN
        w_next = mem_op_de ? ST_MEMACC : ST_WB;
`else
        w_next = ST_MEMACC;
`endif
      end
      ST_MEMACC: begin
        phase_memoryaccess = 1'b1;
        dmem_req           = mem_op_de;
        // Ack wins over the timeout threshold in the same cycle.
        if (!mem_op_de || dmem_ack) w_next = ST_WB;
        else if (w_expire)          w_next = ST_ERR;
      end
      ST_WB: begin
        phase_writeback = 1'b1;
        w_next          = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) w_next = ST_FETCH;
      end
      ST_ERR: begin
        bus_err = 1'b1;
      end
      default: w_next = ST_ERR;
    endcase
  end

  // Retired-instruction counter: one per WRITEBACK, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_instret <= '0;
    else if (r_state == ST_WB) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret            = r_instret;
  assign stall_fetch        = phase_fetch & ~imem_ack;
  assign stall_memoryaccess = phase_memoryaccess & mem_op_de & ~dmem_ack;
  assign stall_decode       = 1'b0;
  assign stall_execute      = 1'b0;
  assign stall_writeback    = 1'b0;

endmodule

// File: tb/tb_core_phase_sequencer.sv
// Directed bench for core_phase_sequencer. Each cycle the expected output
// snapshot is pushed to a scoreboard queue when inputs are driven, then
// popped and compared against the DUT shortly after the falling edge.
module tb_core_phase_sequencer;

  localparam int unsigned TMO = 8;
  localparam int unsigned TW  = 4;
  localparam int unsigned CW  = 4;

  typedef enum int {P_BOOT, P_F, P_D, P_E, P_M, P_W, P_H, P_ERR} ph_e;

  typedef struct packed {
    logic [13:0]   v;
    logic [CW-1:0] cnt;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          mem_op_de = 1'b0;
  logic          halt_req = 1'b0;
  logic          imem_req, dmem_req, halted, bus_err;
  logic          phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback;
  logic          stall_fetch, stall_decode, stall_execute, stall_memoryaccess, stall_writeback;
  logic [CW-1:0] instret;

  snap_t         sb_q[$];
  int            total = 0;
  int            bad = 0;
  int            ncyc = 0;
  logic [CW-1:0] exp_cnt = '0;

  core_phase_sequencer #(
    .TIMEOUT_CYC (TMO),
    .TMO_W       (TW),
    .CNT_W       (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req           (imem_req),
    .imem_ack           (imem_ack),
    .dmem_req           (dmem_req),
    .dmem_ack           (dmem_ack),
    .mem_op_de          (mem_op_de),
    .halt_req           (halt_req),
    .halted             (halted),
    .bus_err            (bus_err),
    .phase_fetch        (phase_fetch),
    .phase_decode       (phase_decode),
    .phase_execute      (phase_execute),
    .phase_memoryaccess (phase_memoryaccess),
    .phase_writeback    (phase_writeback),
    .stall_fetch        (stall_fetch),
    .stall_decode       (stall_decode),
    .stall_execute      (stall_execute),
    .stall_memoryaccess (stall_memoryaccess),
    .stall_writeback    (stall_writeback),
    .instret            (instret)
  );

  always #5 clk = ~clk;

  // Expected outputs for a given phase and the inputs of that cycle.
  function automatic snap_t model(ph_e ph, logic ia, logic da, logic mop, logic [CW-1:0] c);
    snap_t s;
    s.v = {ph == P_F, ph == P_D, ph == P_E, ph == P_M, ph == P_W,
           ph == P_F, (ph == P_M) && mop,
           (ph == P_F) && !ia, (ph == P_M) && mop && !da,
           ph == P_H, ph == P_ERR, 3'b000};
    s.cnt = c;
    return s;
  endfunction

  task automatic check_now(input string tag);
    snap_t e;
    snap_t o;
    e = sb_q.pop_front();
    o.v = {phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback,
           imem_req, dmem_req, stall_fetch, stall_memoryaccess, halted, bus_err,
           stall_decode, stall_execute, stall_writeback};
    o.cnt = instret;
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, push the
  // expectation, then compare.
  task automatic cyc(input ph_e ph, input logic ia, input logic da, input logic hr);
    @(negedge clk);
    imem_ack = ia;
    dmem_ack = da;
    halt_req = hr;
    sb_q.push_back(model(ph, ia, da, mem_op_de, exp_cnt));
    #1;
    ncyc++;
    check_now($sformatf("c%0d_%s", ncyc, ph.name()));
    if (ph == P_W) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic reset_pulse(input string tag);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    halt_req = 1'b0;
    exp_cnt  = '0;
    sb_q.push_back(model(P_BOOT, 1'b0, 1'b0, mem_op_de, exp_cnt));
    #1;
    check_now({tag, "_async"});
    @(negedge clk);
    sb_q.push_back(model(P_BOOT, 1'b0, 1'b0, mem_op_de, exp_cnt));
    #1;
    check_now({tag, "_held"});
    rst_n = 1'b1;
  endtask

  // One instruction: iw fetch wait cycles, dw data wait cycles.
  task automatic instr(input int iw, input int dw, input logic mop, input logic hr);
    bit visit_m;
    mem_op_de = mop;
    visit_m   = 1'b1;
`ifdef CORE_PHASE_SKIP_MEM_EN
    visit_m = mop;
`endif
    for (int i = 0; i < iw; i++) cyc(P_F, 1'b0, 1'b0, 1'b0);
    cyc(P_F, 1'b1, 1'b0, 1'b0);
    cyc(P_D, 1'b1, 1'b1, 1'b0);
    cyc(P_E, 1'b1, 1'b1, hr);
    if (visit_m) begin
      if (mop) for (int i = 0; i < dw; i++) cyc(P_M, 1'b0, 1'b0, hr);
      cyc(P_M, 1'b1, 1'b1, hr);
    end
    cyc(P_W, 1'b1, 1'b1, hr);
  endtask

  initial begin
    #2;
    reset_pulse("por");
    instr(0, 0, 1'b1, 1'b0);   // acks tied high: F,D,E,M,W
    instr(0, 0, 1'b0, 1'b0);   // non-memory op
    instr(3, 0, 1'b1, 1'b0);   // 3 fetch stall cycles
    instr(0, 2, 1'b1, 1'b0);   // 2 data stall cycles
    instr(7, 7, 1'b1, 1'b0);   // acks on the timeout threshold cycle
    instr(0, 0, 1'b1, 1'b1);   // halt requested from EXEC on
    for (int i = 0; i < 3; i++) cyc(P_H, 1'b1, 1'b1, 1'b1);
    cyc(P_H, 1'b0, 1'b0, 1'b0);
    instr(0, 0, 1'b0, 1'b0);   // resumes with FETCH

    // Data handshake never acknowledged: ERR after TMO wait cycles.
    mem_op_de = 1'b1;
    cyc(P_F, 1'b1, 1'b0, 1'b0);
    cyc(P_D, 1'b0, 1'b0, 1'b0);
    cyc(P_E, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(TMO); i++) cyc(P_M, 1'b0, 1'b0, 1'b0);
    cyc(P_ERR, 1'b1, 1'b1, 1'b0);
    cyc(P_ERR, 1'b0, 1'b0, 1'b1);
    cyc(P_ERR, 1'b1, 1'b1, 1'b0);
    reset_pulse("after_dmem_tmo");

    // Reset while a fetch is waiting, then an instruction fetch timeout.
    cyc(P_F, 1'b0, 1'b0, 1'b0);
    cyc(P_F, 1'b0, 1'b0, 1'b0);
    reset_pulse("mid_fetch");
    for (int i = 0; i < int'(TMO); i++) cyc(P_F, 1'b0, 1'b0, 1'b0);
    cyc(P_ERR, 1'b1, 1'b0, 1'b0);
    cyc(P_ERR, 1'b1, 1'b0, 1'b0);
    reset_pulse("after_imem_tmo");

    // 16 retired instructions wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) instr(0, i % 2, 1'(i % 3 == 0), 1'b0);
    instr(0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
